// File: rtl/seq_control_pkg.sv
// Shared types and slot helpers for the instruction sequencer.
package seq_control_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StNext,
    StRestart,
    StCall,
    StWait,
    StOutAdc,
    StOutTime,
    StError
  } state_e;

  // Slot 0 performs no operation.
  localparam int unsigned NopSlot = 0;

  // The last slot always requests a timestamp.
  function automatic int unsigned time_slot(input int unsigned n_dev);
    return n_dev - 1;
  endfunction

  // Number of b-bit words needed to carry a a-bit value.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/seq_control_out_serializer.sv
// Emits a short burst of output words with valid/ready flow control.
// A load captures up to NW words (LSW first); each word is held stable until
// the downstream side accepts it.
module out_serializer #(
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned NW     = 3,
  parameter int unsigned WCNT_W = $clog2(NW + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [NW*OUT_W-1:0]  words,
  input  logic [WCNT_W-1:0]    count,
  input  logic                 out_rdy,
  output logic                 data_out_en,
  output logic [OUT_W-1:0]     data_out,
  output logic                 last
);

  logic [NW*OUT_W-1:0] words_q;
  logic [WCNT_W-1:0]   left_q;

  // Final word of the burst is being accepted this cycle.
  assign last = data_out_en && out_rdy && (left_q == WCNT_W'(1));

  // Word shifter: load the burst, advance only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q     <= '0;
      left_q      <= '0;
      data_out_en <= 1'b0;
      data_out    <= '0;
    end else if (load) begin
      words_q     <= words >> OUT_W;
      left_q      <= count;
      data_out    <= words[OUT_W-1:0];
      data_out_en <= (count != '0);
    end else if (data_out_en && out_rdy) begin
      if (left_q == WCNT_W'(1)) begin
        // Keep the last word on the bus; only the valid drops.
        data_out_en <= 1'b0;
      end else begin
        data_out <= words_q[OUT_W-1:0];
        words_q  <= words_q >> OUT_W;
      end
      left_q <= left_q - WCNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_control.sv
// Instruction sequencer: fetches device-slot instructions, strobes the
// selected device, waits for its completion (with optional timeout) and
// forwards ADC samples or timestamps to the output stream. Can loop the
// program automatically on each clock-divider tick.
module seq_control
  import seq_control_pkg::*;
#(
  parameter int unsigned N_DEV   = 8,
  parameter int unsigned ADC_DEV = 1,
  parameter int unsigned ADC_W   = 14,
  parameter int unsigned TIME_W  = 48,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned DEV_W  = $clog2(N_DEV)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               auto_en,
  input  logic [CNT_W-1:0]   auto_max,
  input  logic [CNT_W-1:0]   timeout,
  input  logic               err_clr,
  output logic               rdy,
  output logic               done,
  output logic [CNT_W-1:0]   auto_count,
  output logic               err,
  output logic [DEV_W-1:0]   err_dev,
  output logic               mem_read,
  output logic               mem_zero,
  input  logic               mem_valid,
  input  logic [DEV_W-1:0]   dev_no,
  input  logic               dev_op_rst,
  output logic [N_DEV-1:0]   dev_cs,
  input  logic [N_DEV-1:0]   dev_rdy,
  output logic               data_out_en,
  input  logic               out_rdy,
  output logic [OUT_W-1:0]   data_out,
  input  logic [ADC_W-1:0]   adc_out,
  input  logic [TIME_W-1:0]  time_out,
  output logic               cd_en,
  input  logic               cd_rdy,
  output logic               clock_clr
);

  localparam int unsigned NW     = ceil_div(TIME_W, OUT_W);
  localparam int unsigned SER_W  = NW * OUT_W;
  localparam int unsigned WCNT_W = $clog2(NW + 1);

  localparam logic [DEV_W-1:0] NopSlotW  = DEV_W'(NopSlot);
  localparam logic [DEV_W-1:0] TimeSlotW = DEV_W'(time_slot(N_DEV));
  localparam logic [DEV_W-1:0] AdcSlotW  = DEV_W'(ADC_DEV);

  state_e             state_q;
  logic [DEV_W-1:0]   slot_q;
  logic               op_rst_q;
  logic               is_dev_q;
  logic               call_ph_q;
  logic [CNT_W-1:0]   wait_cnt_q;

  logic               slot_rdy;
  logic               ser_load;
  logic [SER_W-1:0]   ser_words;
  logic [WCNT_W-1:0]  ser_count;
  logic               ser_last;

  assign rdy      = (state_q == StIdle);
  assign slot_rdy = dev_rdy[slot_q];

  // Serializer load: ADC sample on WAIT completion, time snapshot on CALL entry.
  always_comb begin
    ser_load  = 1'b0;
    ser_words = '0;
    ser_count = '0;
    if (state_q == StWait && slot_rdy && slot_q == AdcSlotW && !op_rst_q) begin
      ser_load               = 1'b1;
      ser_words[ADC_W-1:0]   = adc_out;
      ser_count              = WCNT_W'(1);
    end else if (state_q == StCall && !call_ph_q && slot_q == TimeSlotW) begin
      ser_load               = 1'b1;
      ser_words[TIME_W-1:0]  = time_out;
      ser_count              = WCNT_W'(NW);
    end
  end

  out_serializer #(
    .OUT_W  (OUT_W),
    .NW     (NW),
    .WCNT_W (WCNT_W)
  ) u_out_serializer (
    .clk         (clk),
    .rst         (rst),
    .load        (ser_load),
    .words       (ser_words),
    .count       (ser_count),
    .out_rdy     (out_rdy),
    .data_out_en (data_out_en),
    .data_out    (data_out),
    .last        (ser_last)
  );

  // Sequencer FSM with registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mem_read   <= 1'b0;
      mem_zero   <= 1'b1;
      dev_cs     <= '0;
      cd_en      <= 1'b0;
      clock_clr  <= 1'b1;
      auto_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_dev    <= '0;
      slot_q     <= '0;
      op_rst_q   <= 1'b0;
      is_dev_q   <= 1'b0;
      call_ph_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) begin
            clock_clr <= 1'b0;
            if (auto_en) begin
              cd_en      <= 1'b0;
              mem_zero   <= 1'b1;
              auto_count <= '0;
              state_q    <= StRestart;
            end else begin
              // Release the rewind so the program pointer can advance.
              mem_zero <= 1'b0;
              state_q  <= StNext;
            end
          end
        end

        StRestart: begin
          cd_en    <= 1'b1;
          mem_zero <= 1'b0;
          state_q  <= StNext;
        end

        StNext: begin
          if (en && mem_valid) begin
            mem_read  <= 1'b1;
            slot_q    <= dev_no;
            op_rst_q  <= dev_op_rst;
            call_ph_q <= 1'b0;
            is_dev_q  <= (dev_no != NopSlotW) && (dev_no < TimeSlotW);
            if ((dev_no != NopSlotW) && (dev_no < TimeSlotW)) begin
              dev_cs <= N_DEV'(1) << dev_no;
            end
            state_q <= StCall;
          end else if (en && auto_en) begin
            // Program exhausted in loop mode: park here until the divider ticks.
            if (cd_rdy) begin
              auto_count <= auto_count + CNT_W'(1);
              cd_en      <= 1'b0;
              if (auto_max != '0 && (auto_count + CNT_W'(1)) == auto_max) begin
                done    <= 1'b1;
                state_q <= StIdle;
              end else begin
                mem_zero <= 1'b1;
                state_q  <= StRestart;
              end
            end
          end else begin
            cd_en   <= 1'b0;
            state_q <= StIdle;
          end
        end

        StCall: begin
          if (!call_ph_q) begin
            dev_cs   <= '0;
            mem_read <= 1'b0;
            if (slot_q == TimeSlotW) begin
              state_q <= StOutTime;
            end else if (!is_dev_q) begin
              state_q <= StNext;
            end else begin
              call_ph_q <= 1'b1;
            end
          end else begin
            call_ph_q  <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= StWait;
          end
        end

        StWait: begin
          // Device completion takes priority over a coincident timeout.
          if (slot_rdy) begin
            state_q <= (slot_q == AdcSlotW && !op_rst_q) ? StOutAdc : StNext;
          end else if (timeout != '0 && (wait_cnt_q + CNT_W'(1)) == timeout) begin
            err     <= 1'b1;
            err_dev <= slot_q;
            cd_en   <= 1'b0;
            state_q <= StError;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end

        StOutAdc, StOutTime: begin
          if (ser_last) begin
            state_q <= StNext;
          end
        end

        StError: begin
          mem_read <= 1'b0;
          dev_cs   <= '0;
          cd_en    <= 1'b0;
          if (err_clr) begin
            err     <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_control.sv
// Directed bench for seq_control with memory, device, divider and sink models.
module tb_seq_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, auto_en, err_clr;
  logic [15:0] auto_max, timeout;
  logic        rdy, done, err;
  logic [15:0] auto_count;
  logic [2:0]  err_dev;
  logic        mem_read, mem_zero, mem_valid;
  logic [2:0]  dev_no;
  logic        dev_op_rst;
  logic [7:0]  dev_cs, dev_rdy;
  logic        data_out_en, out_rdy;
  logic [15:0] data_out;
  logic [13:0] adc_out;
  logic [47:0] time_out;
  logic        cd_en, cd_rdy, clock_clr;

  always #5 clk = ~clk;

  seq_control dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .auto_en     (auto_en),
    .auto_max    (auto_max),
    .timeout     (timeout),
    .err_clr     (err_clr),
    .rdy         (rdy),
    .done        (done),
    .auto_count  (auto_count),
    .err         (err),
    .err_dev     (err_dev),
    .mem_read    (mem_read),
    .mem_zero    (mem_zero),
    .mem_valid   (mem_valid),
    .dev_no      (dev_no),
    .dev_op_rst  (dev_op_rst),
    .dev_cs      (dev_cs),
    .dev_rdy     (dev_rdy),
    .data_out_en (data_out_en),
    .out_rdy     (out_rdy),
    .data_out    (data_out),
    .adc_out     (adc_out),
    .time_out    (time_out),
    .cd_en       (cd_en),
    .cd_rdy      (cd_rdy),
    .clock_clr   (clock_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Program memory model.
  logic [2:0] prog_dev [8];
  logic       prog_rst [8];
  int         prog_len, ptr;
  // Device model: cycles from select to ready (0 = never).
  int         dly [8];
  int         dcnt [8];
  // Sink and divider models.
  int          stall_n, stall_c, cd_cnt;
  logic [15:0] exp_q [$];
  logic        hold_pend;
  logic [15:0] prev_data;
  // Event tallies.
  int   cyc, cs_cyc, err_cyc, n_rd, n_done, n_zero_fall, n_words;
  logic prev_zero;
  logic [7:0] last_cs;
  logic first_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then update every model.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (hold_pend && !rst) begin
      chk("hold_valid", 64'(data_out_en), 64'(1));
      chk("hold_data", 64'(data_out), 64'(prev_data));
    end
    if (mem_read) n_rd++;
    if (done) n_done++;
    if (prev_zero && !mem_zero) n_zero_fall++;
    prev_zero = mem_zero;
    if (mem_read) ptr++;
    if (mem_zero) ptr = 0;
    mem_valid  = (ptr < prog_len);
    dev_no     = prog_dev[ptr % 8];
    dev_op_rst = prog_rst[ptr % 8];
    for (int i = 0; i < 8; i++) begin
      if (dev_cs[i]) begin
        dev_rdy[i] = 1'b0;
        dcnt[i]    = dly[i];
        cs_cyc     = cyc;
        last_cs    = dev_cs;
      end else if (dcnt[i] > 0) begin
        dcnt[i]--;
        if (dcnt[i] == 0) dev_rdy[i] = 1'b1;
      end
    end
    if (!cd_en) begin
      cd_cnt = 0;
      cd_rdy = 1'b0;
    end else begin
      cd_cnt++;
      cd_rdy = (cd_cnt % 16 == 0);
    end
    if (data_out_en) begin
      if (stall_c < stall_n) begin
        out_rdy = 1'b0;
        stall_c++;
      end else begin
        out_rdy = 1'b1;
        stall_c = 0;
      end
    end else begin
      out_rdy = 1'b0;
      stall_c = 0;
    end
    if (data_out_en && out_rdy) begin
      n_words++;
      chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) chk("word", 64'(data_out), 64'(exp_q.pop_front()));
    end
    hold_pend = data_out_en && !out_rdy;
    prev_data = data_out;
  endtask

  task automatic check_rst(input string p);
    chk({p, "_rdy"}, 64'(rdy), 64'(1));
    chk({p, "_mem_read"}, 64'(mem_read), 64'(0));
    chk({p, "_mem_zero"}, 64'(mem_zero), 64'(1));
    chk({p, "_dev_cs"}, 64'(dev_cs), 64'(0));
    chk({p, "_data_out_en"}, 64'(data_out_en), 64'(0));
    chk({p, "_data_out"}, 64'(data_out), 64'(0));
    chk({p, "_cd_en"}, 64'(cd_en), 64'(0));
    chk({p, "_clock_clr"}, 64'(clock_clr), 64'(1));
    chk({p, "_auto_count"}, 64'(auto_count), 64'(0));
    chk({p, "_done"}, 64'(done), 64'(0));
    chk({p, "_err"}, 64'(err), 64'(0));
    chk({p, "_err_dev"}, 64'(err_dev), 64'(0));
  endtask

  task automatic load_prog(input logic [2:0] d, input logic r);
    prog_dev[0] = d;
    prog_rst[0] = r;
    prog_len    = 1;
    ptr         = 0;
    n_words     = 0;
    n_rd        = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; auto_en = 1'b0; err_clr = 1'b0;
    auto_max = '0; timeout = '0; mem_valid = 1'b0; dev_no = '0; dev_op_rst = 1'b0;
    dev_rdy = '0; out_rdy = 1'b0; adc_out = '0; time_out = '0; cd_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      prog_dev[i] = '0; prog_rst[i] = 1'b0; dly[i] = 0; dcnt[i] = 0;
    end
    prog_len = 0; ptr = 0; stall_n = 0; stall_c = 0; cd_cnt = 0;
    hold_pend = 1'b0; prev_data = '0; prev_zero = 1'b1; last_cs = '0;
    cyc = 0; cs_cyc = 0; err_cyc = 0; n_rd = 0; n_done = 0; n_zero_fall = 0; n_words = 0;

    repeat (3) cycle();
    check_rst("reset");
    rst = 1'b0;

    // ADC read on slot 1, device ready 3 cycles after select.
    load_prog(3'd1, 1'b0);
    dly[1] = 3;
    adc_out = 14'h1ABC;
    exp_q.push_back(16'h1ABC);
    en = 1'b1;
    for (int i = 0; i < 60 && !data_out_en; i++) cycle();
    chk("adc_valid_seen", 64'(data_out_en), 64'(1));
    chk("adc_latency", 64'(cyc - cs_cyc), 64'(4));
    chk("adc_cs", 64'(last_cs), 64'(8'h02));
    en = 1'b0;
    for (int i = 0; i < 20 && !rdy; i++) cycle();
    repeat (2) cycle();
    chk("adc_rdy", 64'(rdy), 64'(1));
    chk("adc_reads", 64'(n_rd), 64'(1));
    chk("adc_words", 64'(n_words), 64'(1));
    chk("adc_clock_clr", 64'(clock_clr), 64'(0));

    // Timestamp with a 2-cycle stall per word; en drops mid-instruction.
    load_prog(3'd7, 1'b0);
    time_out = 48'h0003_0002_0001;
    stall_n  = 2;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    en = 1'b1;
    first_en = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      cycle();
      if (data_out_en && !first_en) begin
        first_en = 1'b1;
        en       = 1'b0;
        time_out = 48'hFFFF_EEEE_DDDD;
      end
    end
    chk("time_drained", 64'(exp_q.size()), 64'(0));
    for (int i = 0; i < 20 && !rdy; i++) cycle();
    repeat (3) cycle();
    chk("time_rdy", 64'(rdy), 64'(1));
    chk("time_words", 64'(n_words), 64'(3));
    chk("time_cs_none", 64'(last_cs), 64'(8'h02));

    // Auto loop: three passes of a NOP program on divider ticks.
    load_prog(3'd0, 1'b0);
    stall_n = 0;
    auto_en = 1'b1;
    auto_max = 16'd3;
    n_zero_fall = 0;
    n_done = 0;
    en = 1'b1;
    for (int i = 0; i < 400 && !done; i++) cycle();
    chk("auto_done_seen", 64'(done), 64'(1));
    chk("auto_count_at_done", 64'(auto_count), 64'(3));
    en = 1'b0;
    repeat (4) cycle();
    auto_en = 1'b0;
    chk("auto_done_pulses", 64'(n_done), 64'(1));
    chk("auto_rewinds", 64'(n_zero_fall), 64'(3));
    chk("auto_rdy", 64'(rdy), 64'(1));
    chk("auto_cd_en", 64'(cd_en), 64'(0));
    chk("auto_count_hold", 64'(auto_count), 64'(3));

    // Timeout on slot 4, which never answers.
    load_prog(3'd4, 1'b0);
    timeout = 16'd10;
    en = 1'b1;
    for (int i = 0; i < 100 && !err; i++) cycle();
    err_cyc = cyc;
    chk("to_err", 64'(err), 64'(1));
    chk("to_latency", 64'(err_cyc - cs_cyc), 64'(12));
    chk("to_cs", 64'(last_cs), 64'(8'h10));
    chk("to_err_dev", 64'(err_dev), 64'(4));
    chk("to_rdy", 64'(rdy), 64'(0));
    repeat (3) cycle();
    chk("to_err_held", 64'(err), 64'(1));
    chk("to_cs_low", 64'(dev_cs), 64'(0));
    chk("to_cd_en_low", 64'(cd_en), 64'(0));
    err_clr = 1'b1;
    en = 1'b0;
    cycle();
    err_clr = 1'b0;
    chk("to_clr_err", 64'(err), 64'(0));
    chk("to_clr_rdy", 64'(rdy), 64'(1));
    timeout = '0;

    // Reset in the middle of a timestamp burst.
    load_prog(3'd7, 1'b0);
    time_out = 48'h0003_0002_0001;
    stall_n = 1;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    en = 1'b1;
    for (int i = 0; i < 60 && n_words == 0; i++) cycle();
    chk("mid_first_word", 64'(n_words), 64'(1));
    cycle();
    rst = 1'b1;
    en  = 1'b0;
    cycle();
    check_rst("mid_rst");
    rst = 1'b0;
    exp_q.delete();
    repeat (10) cycle();
    chk("mid_no_more_words", 64'(n_words), 64'(1));
    chk("mid_valid_low", 64'(data_out_en), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
